// File: rtl/regfile_writeback.sv
// ---------------------------------------------------------------------------
// regfile_writeback
//   Write-side controller for the 32x32 register file. It is the only
//   source of the register file's write enable, destination and data.
//   Single-cycle ALU results and multi-cycle load returns share one write
//   port. Load returns are buffered in a small FIFO so they can wait while
//   the ALU uses the port. A scoreboard marks registers with a load in
//   flight and drives a combinational hazard flag that stalls issue.
//
// Ports
//   clk, rst                       clock; synchronous active-high reset
//   issue_valid/is_load/rd         instruction issuing this cycle
//   chk_rs1/chk_rs2/chk_rd, hazard operands of the waiting instruction and
//                                  its stall flag (combinational)
//   alu_valid/rd/data, alu_stall   ALU result; stall means "not taken, hold"
//   mem_valid/rd/data, mem_ready   load return handshake
//   reg_write, rd, write_data      registered register-file write port
//   pending_mask                   scoreboard, bit r = load outstanding to xr
//   fifo_count                     number of buffered load returns
// ---------------------------------------------------------------------------
module regfile_writeback #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          issue_valid,
  input  logic                          issue_is_load,
  input  logic [4:0]                    issue_rd,
  input  logic [4:0]                    chk_rs1,
  input  logic [4:0]                    chk_rs2,
  input  logic [4:0]                    chk_rd,
  output logic                          hazard,
  input  logic                          alu_valid,
  input  logic [4:0]                    alu_rd,
  input  logic [XLEN-1:0]               alu_data,
  output logic                          alu_stall,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [4:0]                    mem_rd,
  input  logic [XLEN-1:0]               mem_data,
  output logic                          reg_write,
  output logic [4:0]                    rd,
  output logic [XLEN-1:0]               write_data,
  output logic [31:0]                   pending_mask,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [4:0]       fifo_rd_q   [FIFO_DEPTH];
  logic [4:0]       fifo_rd_d   [FIFO_DEPTH];
  logic [XLEN-1:0]  fifo_data_q [FIFO_DEPTH];
  logic [XLEN-1:0]  fifo_data_d [FIFO_DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      pending_q, pending_d;
  logic             reg_write_q, reg_write_d;
  logic [4:0]       rd_q, rd_d;
  logic [XLEN-1:0]  write_data_q, write_data_d;
  // Set when the write currently on the port came from the FIFO; used to
  // clear that register's scoreboard bit once the write is visible.
  logic             wb_fifo_q, wb_fifo_d;

  logic full_s;
  logic empty_s;
  logic enq_s;
  logic pop_s;

  // FIFO status, load-return handshake and scoreboard hazard lookup
  always_comb begin
    full_s    = (count_q == CNT_W'(FIFO_DEPTH));
    empty_s   = (count_q == {CNT_W{1'b0}});
    mem_ready = ~full_s;
    // Loads to x0 are accepted but dropped, they never occupy a slot.
    enq_s     = mem_valid & ~full_s & (mem_rd != 5'd0);
    hazard    = pending_q[chk_rs1] | pending_q[chk_rs2] | pending_q[chk_rd];
  end

  // Write-port arbitration: a full FIFO has priority so loads cannot starve
  always_comb begin
    pop_s        = 1'b0;
    alu_stall    = 1'b0;
    reg_write_d  = 1'b0;
    rd_d         = rd_q;
    write_data_d = write_data_q;
    wb_fifo_d    = 1'b0;
    if (full_s) begin
      pop_s        = 1'b1;
      alu_stall    = alu_valid;
      reg_write_d  = 1'b1;
      rd_d         = fifo_rd_q[head_q];
      write_data_d = fifo_data_q[head_q];
      wb_fifo_d    = 1'b1;
    end else if (alu_valid) begin
      reg_write_d  = (alu_rd != 5'd0);
      rd_d         = alu_rd;
      write_data_d = alu_data;
    end else if (!empty_s) begin
      pop_s        = 1'b1;
      reg_write_d  = 1'b1;
      rd_d         = fifo_rd_q[head_q];
      write_data_d = fifo_data_q[head_q];
      wb_fifo_d    = 1'b1;
    end else begin
      reg_write_d  = 1'b0;
    end
  end

  // FIFO next state: enqueue at tail, pop at head, pointers wrap naturally
  always_comb begin
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    if (enq_s) begin
      fifo_rd_d[tail_q]   = mem_rd;
      fifo_data_d[tail_q] = mem_data;
      tail_d              = tail_q + PTR_W'(1);
    end else begin
      tail_d              = tail_q;
    end
    if (pop_s) begin
      head_d = head_q + PTR_W'(1);
    end else begin
      head_d = head_q;
    end
    count_d = count_q + CNT_W'(enq_s) - CNT_W'(pop_s);
  end

  // Scoreboard next state: clear first so a same-edge set wins
  always_comb begin
    pending_d = pending_q;
    if (wb_fifo_q & reg_write_q) begin
      pending_d[rd_q] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (issue_valid & issue_is_load & (issue_rd != 5'd0)) begin
      pending_d[issue_rd] = 1'b1;
    end else begin
      pending_d[0] = 1'b0;
    end
  end

  // Control state and write-port registers
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= {PTR_W{1'b0}};
      tail_q       <= {PTR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      pending_q    <= 32'd0;
      reg_write_q  <= 1'b0;
      rd_q         <= 5'd0;
      write_data_q <= {XLEN{1'b0}};
      wb_fifo_q    <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      pending_q    <= pending_d;
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
      write_data_q <= write_data_d;
      wb_fifo_q    <= wb_fifo_d;
    end
  end

  // FIFO payload storage; validity is tracked by the pointers alone
  always_ff @(posedge clk) begin
    fifo_rd_q   <= fifo_rd_d;
    fifo_data_q <= fifo_data_d;
  end

  assign reg_write    = reg_write_q;
  assign rd           = rd_q;
  assign write_data   = write_data_q;
  assign pending_mask = pending_q;
  assign fifo_count   = count_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: a queue-based reference model
// predicts each register-file write (cycle, rd, data) and the per-cycle
// handshake/scoreboard outputs; a monitor consumes the predicted writes.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_is_load;
  logic [4:0]  issue_rd, chk_rs1, chk_rs2, chk_rd;
  logic        hazard;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic [31:0] pending_mask;
  logic [2:0]  fifo_count;

  regfile_writeback #(.XLEN(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_is_load(issue_is_load), .issue_rd(issue_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd), .hazard(hazard),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .reg_write(reg_write), .rd(rd), .write_data(write_data),
    .pending_mask(pending_mask), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
  typedef struct { int cyc; logic [4:0] rd; logic [31:0] data; } exp_t;

  ent_t        mq[$];      // model of buffered load returns
  exp_t        expq[$];    // predicted register-file writes
  logic [4:0]  outst[$];   // loads issued, not yet returned
  logic [31:0] pend;       // model scoreboard
  logic [4:0]  defer_clr;  // register whose write becomes visible next cycle
  int          cycle_cnt = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          started = 1'b0;
  bit          alu_was_stalled, mem_was_blocked;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endtask

  // Reference model, evaluated mid-cycle with inputs stable.
  task automatic model_step();
    bit         full;
    ent_t       e;
    logic [4:0] newdef;
    if (rst) begin
      mq.delete(); outst.delete();
      pend = 32'd0; defer_clr = 5'd0;
      alu_was_stalled = 1'b0; mem_was_blocked = 1'b0;
      return;
    end
    full = (mq.size() == 4);
    chk("mem_ready", mem_ready, !full);
    chk("alu_stall", alu_stall, alu_valid && full);
    chk("fifo_count", fifo_count, mq.size());
    chk("pending_mask", pending_mask, pend);
    chk("hazard", hazard, pend[chk_rs1] | pend[chk_rs2] | pend[chk_rd]);
    alu_was_stalled = alu_valid && full;
    mem_was_blocked = mem_valid && full;
    newdef = 5'd0;
    if (full || (!alu_valid && mq.size() > 0)) begin
      e = mq.pop_front();
      expq.push_back('{cycle_cnt + 1, e.rd, e.data});
      newdef = e.rd;
    end else if (alu_valid && alu_rd != 5'd0) begin
      expq.push_back('{cycle_cnt + 1, alu_rd, alu_data});
    end
    if (mem_valid && !full && mem_rd != 5'd0) begin
      mq.push_back('{mem_rd, mem_data});
      if (outst.size() > 0 && outst[0] == mem_rd) void'(outst.pop_front());
    end
    if (defer_clr != 5'd0) pend[defer_clr] = 1'b0;
    if (issue_valid && issue_is_load && issue_rd != 5'd0) pend[issue_rd] = 1'b1;
    defer_clr = newdef;
  endtask

  // Monitor: every observed write must match the oldest prediction
  always @(negedge clk) begin
    exp_t x;
    if (started) begin
      if (reg_write) begin
        if (expq.size() == 0) begin
          chk("wr_unexpected", reg_write, 1'b0);
        end else begin
          x = expq.pop_front();
          chk("wr_cycle", cycle_cnt, x.cyc);
          chk("wr_rd", rd, x.rd);
          chk("wr_data", write_data, x.data);
        end
      end else if (expq.size() > 0 && expq[0].cyc <= cycle_cnt) begin
        chk("wr_missing", reg_write, 1'b1);
        void'(expq.pop_front());
      end
    end
  end

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_is_load = 1'b0; issue_rd = 5'd0;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
  endtask

  task automatic issue_load(input logic [4:0] r);
    issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = r;
    outst.push_back(r);
  endtask

  initial begin
    logic [4:0] r;
    rst = 1'b1; idle();
    chk_rs1 = 5'd0; chk_rs2 = 5'd0; chk_rd = 5'd0;
    pend = 32'd0; defer_clr = 5'd0;
    alu_was_stalled = 1'b0; mem_was_blocked = 1'b0;

    // Reset held two cycles
    cycle(); cycle();
    rst = 1'b0; started = 1'b1;
    chk("rst_reg_write", reg_write, 1'b0);
    chk("rst_rd", rd, 5'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_mem_ready", mem_ready, 1'b1);
    chk("rst_pending", pending_mask, 32'd0);
    chk("rst_fifo_count", fifo_count, 3'd0);

    // ALU write appears the next cycle only
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    chk("alu_no_stall", alu_stall, 1'b0);
    cycle(); idle();
    chk("alu_we", reg_write, 1'b1);
    chk("alu_rd", rd, 5'd5);
    chk("alu_data", write_data, 32'hDEADBEEF);
    cycle();
    chk("alu_we_once", reg_write, 1'b0);

    // Load to x7: hazard until the write is visible
    issue_load(5'd7); chk_rs1 = 5'd7;
    cycle(); idle();
    chk("ld7_hazard_set", hazard, 1'b1);
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h1234;
    cycle(); idle();
    chk("ld7_no_bypass", reg_write, 1'b0);
    chk("ld7_hazard_n1", hazard, 1'b1);
    cycle();
    chk("ld7_we", reg_write, 1'b1);
    chk("ld7_rd", rd, 5'd7);
    chk("ld7_data", write_data, 32'h1234);
    chk("ld7_hazard_n2", hazard, 1'b1);
    cycle();
    chk("ld7_hazard_n3", hazard, 1'b0);
    chk_rs1 = 5'd0;

    // One buffered entry loses to a same-cycle ALU result
    issue_load(5'd9);
    cycle(); idle();
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
    cycle(); idle();
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA10;
    chk("mix_stall", alu_stall, 1'b0);
    chk("mix_count", fifo_count, 3'd1);
    cycle(); idle();
    chk("mix_first_rd", rd, 5'd10);
    cycle();
    chk("mix_second_rd", rd, 5'd9);
    chk("mix_second_data", write_data, 32'h99);
    cycle();

    // Fill the FIFO behind continuous ALU traffic, then drain in order
    for (int i = 0; i < 4; i++) begin
      issue_load(5'(11 + i));
      cycle();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(20 + i); alu_data = 32'(i);
      mem_valid = 1'b1; mem_rd = 5'(11 + i); mem_data = 32'h1100 + 32'(i);
      cycle();
    end
    idle();
    alu_valid = 1'b1; alu_rd = 5'd24; alu_data = 32'h24;
    chk("full_ready", mem_ready, 1'b0);
    chk("full_stall", alu_stall, 1'b1);
    chk("full_count", fifo_count, 3'd4);
    cycle();
    chk("drain_rd11", rd, 5'd11);
    chk("drain_data11", write_data, 32'h1100);
    cycle(); idle();
    chk("drain_alu24", rd, 5'd24);
    cycle();
    chk("drain_rd12", rd, 5'd12);
    cycle();
    chk("drain_rd13", rd, 5'd13);
    cycle();
    chk("drain_rd14", rd, 5'd14);
    cycle(); cycle();

    // Writes to x0 never reach the register file
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hEEEE;
    cycle(); idle();
    chk("x0_no_we", reg_write, 1'b0);
    chk("x0_not_queued", fifo_count, 3'd0);
    cycle();
    chk("x0_no_we2", reg_write, 1'b0);

    // Reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      issue_load(5'(15 + i));
      cycle();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(25 + i); alu_data = 32'h2500 + 32'(i);
      mem_valid = 1'b1; mem_rd = 5'(15 + i); mem_data = 32'h1500 + 32'(i);
      cycle();
    end
    idle();
    chk("pre_rst_count", fifo_count, 3'd3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_rst_count", fifo_count, 3'd0);
    chk("mid_rst_pending", pending_mask, 32'd0);
    chk("mid_rst_no_we", reg_write, 1'b0);
    cycle();
    chk("mid_rst_no_we2", reg_write, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if (!alu_was_stalled) begin
        alu_valid = ($urandom_range(0, 2) == 0);
        r = 5'($urandom_range(0, 31));
        alu_rd = pend[r] ? 5'd0 : r;
        alu_data = $urandom;
      end
      if (!mem_was_blocked) begin
        if (outst.size() > 0 && $urandom_range(0, 1) == 1) begin
          mem_valid = 1'b1; mem_rd = outst[0]; mem_data = $urandom;
        end else if ($urandom_range(0, 15) == 0) begin
          mem_valid = 1'b1; mem_rd = 5'd0; mem_data = $urandom;
        end else begin
          mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
        end
      end
      issue_valid = 1'b0; issue_is_load = 1'b0; issue_rd = 5'd0;
      if ($urandom_range(0, 2) == 0) begin
        r = 5'($urandom_range(0, 31));
        if (!pend[r] && !(alu_valid && alu_rd == r)) begin
          issue_valid = 1'b1;
          issue_is_load = ($urandom_range(0, 3) != 0);
          issue_rd = r;
          if (issue_is_load && r != 5'd0) outst.push_back(r);
        end
      end
      chk_rs1 = 5'($urandom_range(0, 31));
      chk_rs2 = 5'($urandom_range(0, 31));
      chk_rd  = 5'($urandom_range(0, 31));
      cycle();
    end

    // Drain with a bounded budget
    idle();
    for (int n = 0; n < 40; n++) begin
      if (mq.size() == 0 && expq.size() == 0 && defer_clr == 5'd0) break;
      cycle();
    end
    cycle();
    chk("drain_empty", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
